// File: rtl/vid_sync_trigger_gen_if.sv
// Raster timing bus: GPU register bytes in, sync/enable/trigger outputs out.
interface vid_sync_trigger_gen_if #(
  parameter int HW_REGS = 9
);
  logic [7:0]  hw_regs [2**HW_REGS];
  logic [3:0]  pc_ena;
  logic        hde_out;
  logic        vde_out;
  logic        hs_out;
  logic        vs_out;
  logic [47:0] HV_triggers_out;
  logic [11:0] h_count_out;
  logic [11:0] v_count_out;
  logic        frame_start;

  // Timing generator side.
  modport master (
    input  hw_regs,
    output pc_ena, hde_out, vde_out, hs_out, vs_out,
    output HV_triggers_out, h_count_out, v_count_out, frame_start
  );

  // Register file / layer generator side.
  modport slave (
    output hw_regs,
    input  pc_ena, hde_out, vde_out, hs_out, vs_out,
    input  HV_triggers_out, h_count_out, v_count_out, frame_start
  );
endinterface

// File: rtl/vid_sync_trigger_gen.sv
// Raster timing source: sub-pixel phase, H/V counters, sync/enable decode and
// 48 HV trigger pulses from per-frame shadowed coordinates.
module vid_sync_trigger_gen #(
  parameter int PC_DIV      = 4,
  parameter int H_RES       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_RES       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int HW_REGS     = 9,
  parameter int HW_REG_BASE = 0
) (
  input logic                    clk,
  input logic                    reset,
  vid_sync_trigger_gen_if.master bus
);

  localparam int N_TRIG  = 24;
  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  PC_LAST  = 4'(PC_DIV - 1);
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] HS_START = 12'(H_RES + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_RES + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_RES + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_RES + V_FP + V_SYNC);

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
  } coord_t;

  logic [3:0]  pc;
  logic [11:0] h_count;
  logic [11:0] v_count;
  logic        pix_step;
  logic        last_px;
  logic        last_line;

  coord_t      reg_coord [N_TRIG];
  coord_t      shadow    [N_TRIG];

  logic        hde_d;
  logic        vde_d;
  logic        hs_d;
  logic        vs_d;
  logic        fs_d;
  logic [47:0] trig_d;

  assign pix_step  = (pc == 4'd0);
  assign last_px   = (h_count == H_LAST);
  assign last_line = (v_count == V_LAST);
  assign bus.pc_ena = pc;

  // Sub-pixel phase counter; with PC_DIV=1 it stays at 0 and every clk is a pixel.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               pc <= 4'd0;
    else if (pc == PC_LAST)  pc <= 4'd0;
    else                     pc <= pc + 4'd1;
  end

  // Raster position: h wraps at end of line and carries into v, v wraps at end of frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count <= 12'd0;
      v_count <= 12'd0;
    end else if (pix_step) begin
      if (last_px) begin
        h_count <= 12'd0;
        v_count <= last_line ? 12'd0 : v_count + 12'd1;
      end else begin
        h_count <= h_count + 12'd1;
      end
    end
  end

  // Unpack the 96-byte register block into 24 live X/Y pairs (upper nibbles dropped).
  always_comb begin
    for (int k = 0; k < N_TRIG; k++) begin
      reg_coord[k].x = {bus.hw_regs[HW_REG_BASE + 4*k + 1][3:0], bus.hw_regs[HW_REG_BASE + 4*k]};
      reg_coord[k].y = {bus.hw_regs[HW_REG_BASE + 4*k + 3][3:0], bus.hw_regs[HW_REG_BASE + 4*k + 2]};
    end
  end

  // Shadow copy taken on the last pixel of the frame so host writes never tear a frame.
  // NOTE: the shadow array is reset (flip-flops, not RAM) because 0xFFF must silence triggers after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_TRIG; k++) shadow[k] <= {12'hFFF, 12'hFFF};
    end else if (pix_step && last_px && last_line) begin
      shadow <= reg_coord;
    end
  end

  // Timing and trigger decode from the current (pre-increment) position.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    hde_d  = 1'b0;
    vde_d  = 1'b0;
    hs_d   = ~HS_POL;
    vs_d   = ~VS_POL;
    fs_d   = 1'b0;
    trig_d = '0;
    hde_d  = (h_count < 12'(H_RES));
    vde_d  = (v_count < 12'(V_RES));
    if (h_count >= HS_START && h_count < HS_END) hs_d = HS_POL;
    if (v_count >= VS_START && v_count < VS_END) vs_d = VS_POL;
    fs_d = (h_count == 12'd0) && (v_count == 12'd0);
    for (int k = 0; k < N_TRIG; k++) begin
      trig_d[2*k]   = (h_count == shadow[k].x) && (v_count == shadow[k].y);
      trig_d[2*k+1] = (h_count == shadow[k].x);
    end
  end

  // Output registers, updated once per pixel so values hold across all sub-cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.hde_out         <= 1'b0;
      bus.vde_out         <= 1'b0;
      bus.hs_out          <= 1'b0;
      bus.vs_out          <= 1'b0;
      bus.frame_start     <= 1'b0;
      bus.HV_triggers_out <= '0;
      bus.h_count_out     <= 12'd0;
      bus.v_count_out     <= 12'd0;
    end else if (pix_step) begin
      bus.hde_out         <= hde_d;
      bus.vde_out         <= vde_d;
      bus.hs_out          <= hs_d;
      bus.vs_out          <= vs_d;
      bus.frame_start     <= fs_d;
      bus.HV_triggers_out <= trig_d;
      bus.h_count_out     <= h_count;
      bus.v_count_out     <= v_count;
    end
  end

endmodule

// File: tb/tb_vid_sync_trigger_gen.sv
// Scoreboard bench for vid_sync_trigger_gen on a reduced 25x13 raster.
module tb_vid_sync_trigger_gen;

  localparam int PC_DIV  = 4;
  localparam int H_RES   = 16;
  localparam int H_FP    = 2;
  localparam int H_SYNC  = 4;
  localparam int H_BP    = 3;
  localparam int V_RES   = 8;
  localparam int V_FP    = 1;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 2;
  localparam bit HS_POL  = 1'b0;
  localparam bit VS_POL  = 1'b1;
  localparam int HW_REGS = 9;
  localparam int BASE    = 4;
  localparam int H_TOTAL = 25;
  localparam int V_TOTAL = 13;

  typedef struct packed {
    logic [3:0]  pc;
    logic        hde;
    logic        vde;
    logic        hs;
    logic        vs;
    logic [47:0] trig;
    logic [11:0] h;
    logic [11:0] v;
    logic        fs;
  } out_t;

  typedef struct {
    out_t o;
    bit   first;
  } entry_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vid_sync_trigger_gen_if #(.HW_REGS(HW_REGS)) bus ();

  vid_sync_trigger_gen #(
    .PC_DIV(PC_DIV), .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .HW_REGS(HW_REGS), .HW_REG_BASE(BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic out_t get_obs();
    out_t o;
    o.pc   = bus.pc_ena;
    o.hde  = bus.hde_out;
    o.vde  = bus.vde_out;
    o.hs   = bus.hs_out;
    o.vs   = bus.vs_out;
    o.trig = bus.HV_triggers_out;
    o.h    = bus.h_count_out;
    o.v    = bus.v_count_out;
    o.fs   = bus.frame_start;
    return o;
  endfunction

  // ---------------- reference model: pushes one expected entry per clk ----------------
  entry_t      sb[$];
  int          m_pc, m_x, m_y, m_frame;
  logic [11:0] m_sx [24];
  logic [11:0] m_sy [24];
  out_t        m_out;
  entry_t      m_e;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      m_pc = 0; m_x = 0; m_y = 0; m_frame = 0;
      m_out = '0;
      for (int k = 0; k < 24; k++) begin m_sx[k] = 12'hFFF; m_sy[k] = 12'hFFF; end
    end else begin
      m_e.first = (m_pc == 0);
      if (m_pc == 0) begin
        m_out.hde = (m_x < H_RES);
        m_out.vde = (m_y < V_RES);
        m_out.hs  = (m_x >= 18 && m_x <= 21) ? HS_POL : ~HS_POL;
        m_out.vs  = (m_y >= 9 && m_y <= 10) ? VS_POL : ~VS_POL;
        m_out.fs  = (m_x == 0 && m_y == 0);
        m_out.h   = 12'(m_x);
        m_out.v   = 12'(m_y);
        for (int k = 0; k < 24; k++) begin
          m_out.trig[2*k]   = (12'(m_x) == m_sx[k]) && (12'(m_y) == m_sy[k]);
          m_out.trig[2*k+1] = (12'(m_x) == m_sx[k]);
        end
        if (m_x == H_TOTAL-1 && m_y == V_TOTAL-1)
          for (int k = 0; k < 24; k++) begin
            m_sx[k] = {bus.hw_regs[BASE+4*k+1][3:0], bus.hw_regs[BASE+4*k]};
            m_sy[k] = {bus.hw_regs[BASE+4*k+3][3:0], bus.hw_regs[BASE+4*k+2]};
          end
        if (m_x == H_TOTAL-1) begin
          m_x = 0;
          if (m_y == V_TOTAL-1) begin m_y = 0; m_frame++; end
          else m_y++;
        end else m_x++;
      end
      m_pc = (m_pc == PC_DIV-1) ? 0 : m_pc + 1;
      m_out.pc = 4'(m_pc);
      m_e.o = m_out;
      sb.push_back(m_e);
    end
  end

  // ---------------- monitor: pops and compares, tallies pixel events ----------------
  entry_t      mon_e;
  out_t        mon_o;
  int          trig_cnt [48];
  int          fs_cnt = 0;
  int          line_hde = 0, line_hs = 0, frame_vs = 0, frame_vde = 0;
  logic [11:0] t8_v[$];

  initial for (int b = 0; b < 48; b++) trig_cnt[b] = 0;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      check("in_reset", 128'(get_obs()), 128'(0));
      line_hde = 0; line_hs = 0; frame_vs = 0; frame_vde = 0;
    end else if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      mon_o = get_obs();
      check("scoreboard", 128'(mon_o), 128'(mon_e.o));
      if (mon_e.first) begin
        for (int b = 0; b < 48; b++) if (mon_o.trig[b]) trig_cnt[b]++;
        if (mon_o.fs) fs_cnt++;
        if (mon_o.trig[8]) begin
          t8_v.push_back(mon_o.v);
          check("trig8_x", 128'(mon_o.h), 128'(10));
        end
        if (mon_o.hde) line_hde++;
        if (mon_o.hs == HS_POL) line_hs++;
        if (mon_e.o.h == 0) begin
          if (mon_o.vs == VS_POL) frame_vs++;
          if (mon_o.vde) frame_vde++;
        end
        if (mon_e.o.h == 12'(H_TOTAL-1)) begin
          check("line_hde", 128'(line_hde), 128'(16));
          check("line_hs", 128'(line_hs), 128'(4));
          line_hde = 0; line_hs = 0;
          if (mon_e.o.v == 12'(V_TOTAL-1)) begin
            check("frame_vs_lines", 128'(frame_vs), 128'(2));
            check("frame_vde_lines", 128'(frame_vde), 128'(8));
            frame_vs = 0; frame_vde = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic write_xy(input int k, input logic [11:0] x, input logic [11:0] y, input logic [3:0] junk);
    bus.hw_regs[BASE+4*k]   = x[7:0];
    bus.hw_regs[BASE+4*k+1] = {junk, x[11:8]};
    bus.hw_regs[BASE+4*k+2] = y[7:0];
    bus.hw_regs[BASE+4*k+3] = {junk, y[11:8]};
  endtask

  task automatic wait_pos(input int f, input int x, input int y);
    int n = 0;
    bit hit = 0;
    while (!hit && n < 20000) begin
      @(posedge clk); #2;
      n++;
      hit = (m_frame == f && m_x == x && m_y == y);
    end
    check($sformatf("wait_pos(%0d,%0d,%0d)", f, x, y), 128'(hit), 128'(1));
  endtask

  int exp_cnt [48];

  initial begin
    for (int i = 0; i < 2**HW_REGS; i++) bus.hw_regs[i] = 8'hFF;
    for (int b = 0; b < 48; b++) exp_cnt[b] = 0;
    exp_cnt[6] = 3;  exp_cnt[7] = 37;
    exp_cnt[8] = 3;  exp_cnt[9] = 36;
    exp_cnt[15] = 36;

    #1 reset = 1'b1;
    #1 check("reset_outputs", 128'(get_obs()), 128'(0));
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    write_xy(3, 12'd0,   12'd0,  4'h5);
    write_xy(4, 12'd10,  12'd5,  4'hF);
    write_xy(5, 12'd30,  12'd0,  4'h0);
    write_xy(6, 12'd900, 12'd2,  4'h0);
    write_xy(7, 12'd7,   12'd20, 4'h3);

    wait_pos(1, 0, 8);
    write_xy(4, 12'd10, 12'd9, 4'hA);

    wait_pos(2, 5, 10);
    reset = 1'b1;
    #1 check("async_reset", 128'(get_obs()), 128'(0));
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    wait_pos(2, 0, 0);
    @(negedge clk); #1;

    for (int b = 0; b < 48; b++)
      check($sformatf("trig_cnt[%0d]", b), 128'(trig_cnt[b]), 128'(exp_cnt[b]));
    check("frame_start_cnt", 128'(fs_cnt), 128'(5));
    check("trig8_pulses", 128'(t8_v.size()), 128'(3));
    if (t8_v.size() == 3) begin
      check("trig8_y_f1", 128'(t8_v[0]), 128'(5));
      check("trig8_y_f2", 128'(t8_v[1]), 128'(9));
      check("trig8_y_post_reset", 128'(t8_v[2]), 128'(9));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
